// File: rtl/result_display_pkg.sv
// result_display_pkg: shared constants and types for the result display scanner
package result_display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/result_display_scanner_hex_to_seg7.sv
// hex_to_seg7: active-low nibble to seven-segment lookup with blanking
module hex_to_seg7
  import result_display_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = blank ? SEG_BLANK : SEG_TABLE[nib];
endmodule

// File: rtl/result_display_scanner.sv
// result_display_scanner: captures result on each button step and scans it onto a 4-digit display
module result_display_scanner
  import result_display_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter int SYNC_STAGES   = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CLK_BUTT,
  input  logic [15:0]           result,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  logic [CW-1:0]          cnt;
  digit_idx_t             idx;
  logic [15:0]            disp_q;
  logic                   step_par;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   rise;
  logic                   wrap;
  logic                   blank;
  logic                   off;
  logic [3:0]             nib;
  logic [6:0]             seg_d;
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev;
  assign wrap  = cnt == CW'(REFRESH_DIV - 1);
  assign nib   = disp_q[{idx, 2'b00} +: 4];
  assign blank = (BLANK_LEADING != 0) && (idx != 2'd0) && ((disp_q >> {idx, 2'b00}) == 16'h0);
  assign off   = (cnt == '0) || blank;
  hex_to_seg7 u_dec (
    .nib  (nib),
    .blank(off),
    .seg  (seg_d)
  );
  // synchronise the step button and capture result once per rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      prev     <= 1'b0;
      disp_q   <= '0;
      step_par <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], CLK_BUTT};
      prev   <= sync_q[SYNC_STAGES-1];
      if (rise) begin
        disp_q   <= result;
        step_par <= ~step_par;
      end
    end
  end
  // slot timer and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      idx <= wrap ? idx + 2'd1 : idx;
    end
  end
  // registered drive; anodes dark in slot cycle 0 to avoid ghosting
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= off ? '1 : ~(4'b0001 << idx);
      seg <= seg_d;
      dp  <= ~(!off && idx == 2'd0 && step_par);
    end
  end
endmodule

// File: tb/tb_result_display_scanner.sv
// tb_result_display_scanner: directed scoreboard bench for the result display scanner
module tb_result_display_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CLK_BUTT = 1'b0;
  logic [15:0] result = 16'hFFFF;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;
  int          total = 0;
  int          bad = 0;
  int          kk = 0;
  logic [15:0] cur_disp = 16'h0;
  logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct packed {
    logic [3:0] an_a;
    logic [6:0] seg_a;
    logic       dp_a;
    logic [3:0] an_b;
    logic [6:0] seg_b;
    logic       dp_b;
  } scan_t;
  scan_t       sq[$];
  logic [15:0] cq[$];

  result_display_scanner #(.REFRESH_DIV(4), .SYNC_STAGES(2), .BLANK_LEADING(1)) dut_a (
    .clk(clk), .reset(reset), .CLK_BUTT(CLK_BUTT), .result(result),
    .seg(seg_a), .dp(dp_a), .an(an_a)
  );
  result_display_scanner #(.REFRESH_DIV(4), .SYNC_STAGES(2), .BLANK_LEADING(0)) dut_b (
    .clk(clk), .reset(reset), .CLK_BUTT(CLK_BUTT), .result(result),
    .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) kk <= reset ? 0 : kk + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic scan_t model(input int k, input logic [15:0] d, input logic p);
    scan_t m;
    int i = (k / 4) % 4;
    int c = k % 4;
    logic [15:0] up = d >> (4 * i);
    logic la = (c != 0) && !(i != 0 && up == 16'h0);
    logic lb = (c != 0);
    logic [3:0] on = ~(4'b0001 << i);
    m.an_a  = la ? on : 4'hF;
    m.seg_a = la ? tbl[up[3:0]] : 7'h7F;
    m.dp_a  = !(la && i == 0 && p);
    m.an_b  = lb ? on : 4'hF;
    m.seg_b = lb ? tbl[up[3:0]] : 7'h7F;
    m.dp_b  = !(lb && i == 0 && p);
    return m;
  endfunction

  task automatic run_scan(input int n, input logic [15:0] d, input logic p);
    scan_t e;
    for (int j = 0; j < n; j++) sq.push_back(model(kk + j, d, p));
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      e = sq.pop_front();
      chk("an_a", 32'(an_a), 32'(e.an_a));
      chk("seg_a", 32'(seg_a), 32'(e.seg_a));
      chk("dp_a", 32'(dp_a), 32'(e.dp_a));
      chk("an_b", 32'(an_b), 32'(e.an_b));
      chk("seg_b", 32'(seg_b), 32'(e.seg_b));
      chk("dp_b", 32'(dp_b), 32'(e.dp_b));
    end
  endtask

  task automatic pulse(input logic [15:0] v, input logic p);
    result = v;
    cq.push_back(v);
    CLK_BUTT = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_cap", 32'(dut_a.disp_q), 32'(cur_disp));
    @(negedge clk);
    chk("cap", 32'(dut_a.disp_q), 32'(cq.pop_front()));
    chk("cap_b", 32'(dut_b.disp_q), 32'(v));
    chk("par", 32'(dut_a.step_par), 32'(p));
    cur_disp = v;
    CLK_BUTT = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", 32'(an_a), 32'hF);
      chk("rst_seg", 32'(seg_a), 32'h7F);
      chk("rst_dp", 32'(dp_a), 32'h1);
    end
    reset = 1'b0;
    run_scan(16, 16'h0000, 1'b0);
    pulse(16'h00A1, 1'b1);
    run_scan(16, 16'h00A1, 1'b1);
    result = 16'h1234;
    repeat (50) @(negedge clk);
    chk("static_disp", 32'(dut_a.disp_q), 32'h00A1);
    chk("static_par", 32'(dut_a.step_par), 32'h1);
    run_scan(16, 16'h00A1, 1'b1);
    result = 16'h8000;
    cq.push_back(16'h8000);
    CLK_BUTT = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_cap", 32'(dut_a.disp_q), 32'(cq.pop_front()));
    result = 16'h5555;
    repeat (30) @(negedge clk);
    chk("hold_disp", 32'(dut_a.disp_q), 32'h8000);
    chk("hold_par", 32'(dut_a.step_par), 32'h0);
    run_scan(16, 16'h8000, 1'b0);
    CLK_BUTT = 1'b0;
    repeat (5) @(negedge clk);
    chk("fall_disp", 32'(dut_a.disp_q), 32'h8000);
    cur_disp = 16'h8000;
    for (int j = 0; j < 16 && (kk % 16) != 9; j++) @(negedge clk);
    chk("pre_rst_idx", 32'(dut_a.idx), 32'h2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cnt", 32'(dut_a.cnt), 32'h0);
    chk("mid_rst_idx", 32'(dut_a.idx), 32'h0);
    chk("mid_rst_disp", 32'(dut_a.disp_q), 32'h0);
    chk("mid_rst_par", 32'(dut_a.step_par), 32'h0);
    chk("mid_rst_an", 32'(an_a), 32'hF);
    reset = 1'b0;
    cur_disp = 16'h0;
    pulse(16'h0C3E, 1'b1);
    pulse(16'hF00D, 1'b0);
    run_scan(16, 16'hF00D, 1'b0);
    pulse(16'h0B07, 1'b1);
    run_scan(16, 16'h0B07, 1'b1);
    chk("sb_empty", 32'(cq.size() + sq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
